// File: rtl/npu_lb_pkg.sv
// Shared definitions for the LineBuffer writer, LineBuffer and convolve blocks.
package npu_lb_pkg;

    localparam int DEF_BIT_DEPTH = 8;
    localparam int DEF_COLS      = 28;
    localparam int DEF_IMG_ROWS  = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CONV   = 2'd2,
        WAIT   = 2'd3
    } lb_state_e;

    // A stride of 0 behaves as 1.
    function automatic logic [1:0] stride_eff(input logic [1:0] s);
        return (s == 2'd0) ? 2'd1 : s;
    endfunction

endpackage

// File: rtl/line_buffer_loader_if.sv
// Pixel stream, LineBuffer write port and convolve handshake of the line buffer loader.
// master: the loader; slave: the pixel source / LineBuffer / convolve side.
interface line_buffer_loader_if
    import npu_lb_pkg::*;
#(
    parameter int BIT_DEPTH = DEF_BIT_DEPTH
);
    logic                 pix_valid;
    logic                 pix_ready;
    logic [BIT_DEPTH-1:0] pix_data;
    logic                 lb_wr_en;
    logic [BIT_DEPTH-1:0] lb_data_r1;
    logic [BIT_DEPTH-1:0] lb_data_r2;
    logic [BIT_DEPTH-1:0] lb_data_r3;
    logic                 conv_start;
    logic                 conv_done;

    modport master (
        input  pix_valid, pix_data, conv_done,
        output pix_ready, lb_wr_en, lb_data_r1, lb_data_r2, lb_data_r3, conv_start
    );

    modport slave (
        output pix_valid, pix_data, conv_done,
        input  pix_ready, lb_wr_en, lb_data_r1, lb_data_r2, lb_data_r3, conv_start
    );
endinterface

// File: rtl/line_buffer_loader_row_history.sv
// Two-row pixel history: bank0 holds row n-2, bank1 holds row n-1, one column per access.
// Reads are combinational (old contents); the write shifts bank1 into bank0 and stores the
// new pixel into bank1 at the same column. zero_top loads zero into bank0 instead.
module row_history #(
    parameter int BIT_DEPTH = 8,
    parameter int COLS      = 28
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(COLS)-1:0]  col,
    input  logic                     zero_top,
    input  logic [BIT_DEPTH-1:0]     din,
    output logic [BIT_DEPTH-1:0]     top,
    output logic [BIT_DEPTH-1:0]     mid
);
    logic [BIT_DEPTH-1:0] bank0_q [COLS];
    logic [BIT_DEPTH-1:0] bank1_q [COLS];

    assign top = bank0_q[col];
    assign mid = bank1_q[col];

    // Column shift of the history; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank0_q[col] <= zero_top ? '0 : bank1_q[col];
            bank1_q[col] <= din;
        end
    end
endmodule

// File: rtl/line_buffer_loader.sv
// Writer side of the 3-row LineBuffer: streams raster pixels into a row history, writes
// column-aligned row triplets for window-bottom rows, then hands each band to convolve.
// Optional build macro ZERO_PAD_EN: one zero row of vertical padding top and bottom.
module line_buffer_loader
    import npu_lb_pkg::*;
#(
    parameter int BIT_DEPTH = DEF_BIT_DEPTH,
    parameter int COLS      = DEF_COLS,
    parameter int IMG_ROWS  = DEF_IMG_ROWS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [1:0]           stride,
    line_buffer_loader_if.master bus,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(IMG_ROWS + 1);
    localparam logic [COL_W-1:0] LAST_COL    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_IN_ROW = ROW_W'(IMG_ROWS - 1);
`ifdef ZERO_PAD_EN
    // Virtual row -1 is zero, so row 1 is the first window bottom.
    localparam logic       PAD_EN      = 1'b1;
    localparam logic [1:0] FIRST_PHASE = 2'd1;
`else
    localparam logic       PAD_EN      = 1'b0;
    localparam logic [1:0] FIRST_PHASE = 2'd2;
`endif

    lb_state_e            state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    // Rows left until the next window bottom; 0 means the current row is a bottom.
    logic [1:0]           phase_q, phase_d;
    logic [1:0]           stride_q, stride_d;
    // Internally generated trailing zero row (padding only).
    logic                 pad_row_q, pad_row_d;
    logic                 wr_en_q, wr_en_d;
    logic [BIT_DEPTH-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic                 conv_start_q, conv_start_d;
    logic                 frame_done_q, frame_done_d;

    logic                 xfer;
    logic                 bottom_row;
    logic                 more_rows;
    logic [1:0]           phase_adv;
    logic [BIT_DEPTH-1:0] pix_in;
    logic [BIT_DEPTH-1:0] hist_top, hist_mid;

    assign xfer       = (state_q == STREAM) && (pad_row_q || bus.pix_valid);
    assign pix_in     = pad_row_q ? '0 : bus.pix_data;
    assign bottom_row = (phase_q == 2'd0);
    assign phase_adv  = bottom_row ? (stride_q - 2'd1) : (phase_q - 2'd1);
    assign more_rows  = (row_q < LAST_IN_ROW) ||
                        (PAD_EN && (row_q == LAST_IN_ROW) && (phase_adv == 2'd0));

    row_history #(
        .BIT_DEPTH (BIT_DEPTH),
        .COLS      (COLS)
    ) u_hist (
        .clk      (clk),
        .wr_en    (xfer),
        .col      (col_q),
        .zero_top (PAD_EN && (row_q == '0)),
        .din      (pix_in),
        .top      (hist_top),
        .mid      (hist_mid)
    );

    // Next-state and registered-output logic of the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        phase_d      = phase_q;
        stride_d     = stride_q;
        pad_row_d    = pad_row_q;
        wr_en_d      = 1'b0;
        r1_d         = r1_q;
        r2_d         = r2_q;
        r3_d         = r3_q;
        conv_start_d = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = STREAM;
                    row_d     = '0;
                    col_d     = '0;
                    phase_d   = FIRST_PHASE;
                    stride_d  = stride_eff(stride);
                    pad_row_d = 1'b0;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (bottom_row) begin
                        wr_en_d = 1'b1;
                        r1_d    = hist_top;
                        r2_d    = hist_mid;
                        r3_d    = pix_in;
                    end
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (bottom_row) begin
                            state_d = CONV;
                        end else if (more_rows) begin
                            row_d     = row_q + ROW_W'(1);
                            phase_d   = phase_adv;
                            pad_row_d = PAD_EN && (row_q == LAST_IN_ROW);
                        end else begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                            pad_row_d    = 1'b0;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            CONV: begin
                conv_start_d = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                // A done coinciding with our own start pulse belongs to no band.
                if (bus.conv_done && !conv_start_q) begin
                    if (more_rows) begin
                        state_d   = STREAM;
                        row_d     = row_q + ROW_W'(1);
                        phase_d   = phase_adv;
                        pad_row_d = PAD_EN && (row_q == LAST_IN_ROW);
                    end else begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        pad_row_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            phase_q      <= '0;
            stride_q     <= 2'd1;
            pad_row_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            r1_q         <= '0;
            r2_q         <= '0;
            r3_q         <= '0;
            conv_start_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            stride_q     <= stride_d;
            pad_row_q    <= pad_row_d;
            wr_en_q      <= wr_en_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            r3_q         <= r3_d;
            conv_start_q <= conv_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = (state_q == STREAM) && !pad_row_q;
    assign bus.lb_wr_en   = wr_en_q;
    assign bus.lb_data_r1 = r1_q;
    assign bus.lb_data_r2 = r2_q;
    assign bus.lb_data_r3 = r3_q;
    assign bus.conv_start = conv_start_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_line_buffer_loader.sv
// Bench for line_buffer_loader: random/pattern frames against a band-level reference model.
module tb_line_buffer_loader;
    import npu_lb_pkg::*;

    localparam int BD    = 8;
    localparam int COLS  = 28;
    localparam int ROWS  = 28;
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] stride = 2'd0;
    logic       busy;
    logic       frame_done;

    line_buffer_loader_if #(.BIT_DEPTH(BD)) bus ();

    line_buffer_loader #(
        .BIT_DEPTH (BD),
        .COLS      (COLS),
        .IMG_ROWS  (ROWS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .stride      (stride),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BD-1:0] r1;
        logic [BD-1:0] r2;
        logic [BD-1:0] r3;
    } trip_t;

    int total = 0;
    int bad   = 0;

    logic [BD-1:0] img [ROWS][COLS];
    trip_t         exp_q[$];
    int            exp_bands;

    bit    mon_en = 0, stop = 0, hold = 0, start_due = 0, exp_wr = 0;
    int    xfer_cnt, band_w, starts, fd_cnt, cur_s;
    trip_t mon_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [BD-1:0] pix_at(input int r, input int c);
        if (r < 0 || r >= ROWS) return '0;
        return img[r][c];
    endfunction

    // Window-bottom rule in input-row numbering (padding adds virtual rows -1 and ROWS).
    function automatic bit is_bottom(input int n, input int s);
`ifdef ZERO_PAD_EN
        return (n >= 1) && (n <= ROWS) && (((n - 1) % s) == 0);
`else
        return (n >= 2) && (n < ROWS) && (((n - 2) % s) == 0);
`endif
    endfunction

    function automatic int lit_bands(input int s);
`ifdef ZERO_PAD_EN
        case (s) 1: return 28; 2: return 14; default: return 10; endcase
`else
        case (s) 1: return 26; 2: return 13; default: return 9; endcase
`endif
    endfunction

    task automatic build_model(input int s);
        trip_t t;
        exp_q.delete();
        exp_bands = 0;
        for (int n = 0; n <= ROWS; n++) begin
            if (is_bottom(n, s)) begin
                exp_bands++;
                for (int c = 0; c < COLS; c++) begin
                    t.r1 = pix_at(n - 2, c);
                    t.r2 = pix_at(n - 1, c);
                    t.r3 = pix_at(n, c);
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
`ifdef ZERO_PAD_EN
            if (xfer_cnt < ROWS * COLS) check("wr_en_timing", bus.lb_wr_en, exp_wr);
`else
            check("wr_en_timing", bus.lb_wr_en, exp_wr);
`endif
            exp_wr = (bus.pix_valid && bus.pix_ready) ? is_bottom(xfer_cnt / COLS, cur_s) : 1'b0;
            if (bus.pix_valid && bus.pix_ready) xfer_cnt++;
            check("conv_start", bus.conv_start, start_due);
            if (bus.conv_start) starts++;
            start_due = 0;
            if (bus.lb_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", bus.lb_wr_en, 0);
                end else begin
                    mon_t = exp_q.pop_front();
                    check("r1", bus.lb_data_r1, mon_t.r1);
                    check("r2", bus.lb_data_r2, mon_t.r2);
                    check("r3", bus.lb_data_r3, mon_t.r3);
                end
                band_w++;
                if (band_w == COLS) begin
                    band_w    = 0;
                    start_due = 1;
                    hold      = 1;
                end
            end
            if (hold) begin
                check("pix_ready_in_band_wait", bus.pix_ready, 0);
                if (bus.conv_done && !bus.conv_start && !start_due) hold = 0;
            end
            if (frame_done) begin
                fd_cnt++;
                check("busy_at_frame_done", busy, 0);
                stop = 1;
            end
        end
    end

    task automatic drive_pixels(input int gap, input int abort_at);
        int k = 0;
        bit fs_done = 0;
        while (k < ROWS * COLS && !stop) begin
            if (k == abort_at) begin
                bus.pix_valid = 1'b0;
                stop = 1;
                break;
            end
            @(posedge clk); #1;
            // A mid-frame frame_start with a different stride must be ignored.
            frame_start = (k >= 100) && !fs_done;
            if (frame_start) begin
                fs_done = 1;
                stride  = stride + 2'd1;
            end
            bus.pix_valid = ($urandom_range(99) >= gap);
            bus.pix_data  = img[k / COLS][k % COLS];
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) k++;
        end
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        frame_start   = 1'b0;
    endtask

    // dmode 0: fixed delay dmax, 1: random 1..dmax, 2: conv_done held high.
    task automatic respond(input int dmode, input int dmax);
        if (dmode == 2) begin
            bus.conv_done = 1'b1;
            while (!stop) @(negedge clk);
        end else begin
            while (!stop) begin
                @(negedge clk);
                if (bus.conv_start && !stop) begin
                    int d;
                    d = (dmode == 0) ? dmax : $urandom_range(dmax, 1);
                    for (int i = 0; i < d && !stop; i++) @(posedge clk);
                    #1 bus.conv_done = 1'b1;
                    @(posedge clk);
                    #1 bus.conv_done = 1'b0;
                end
            end
        end
        bus.conv_done = 1'b0;
    endtask

    task automatic watch_end();
        int n = 0;
        while (!stop && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("frame_end_seen", stop, 1);
        stop = 1;
    endtask

    task automatic run_frame(input int s, input bit pattern, input int gap,
                             input int dmode, input int dmax, input int abort_at);
        int se;
        se = (s == 0) ? 1 : s;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = pattern ? BD'(r * COLS + c) : BD'($urandom);
        build_model(se);
        check("model_bands", exp_bands, lit_bands(se));
        if (pattern) begin
`ifdef ZERO_PAD_EN
            check("model_first_r1", exp_q[0].r1, 0);
            check("model_first_r2", exp_q[0].r2, 0);
            check("model_first_r3", exp_q[0].r3, 28);
`else
            check("model_first_r1", exp_q[0].r1, 0);
            check("model_first_r2", exp_q[0].r2, 28);
            check("model_first_r3", exp_q[0].r3, 56);
`endif
        end
        cur_s = se; xfer_cnt = 0; band_w = 0; starts = 0; fd_cnt = 0;
        hold = 0; start_due = 0; exp_wr = 0; stop = 0;
        mon_en = 1;
        @(posedge clk); #1;
        stride      = s[1:0];
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        fork
            drive_pixels(gap, abort_at);
            respond(dmode, dmax);
            watch_end();
        join
        if (abort_at >= 0) begin
            mon_en = 0;
            rst = 1'b0;
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_pix_ready", bus.pix_ready, 0);
            check("rst_wr_en", bus.lb_wr_en, 0);
            check("rst_conv_start", bus.conv_start, 0);
            repeat (2) begin
                @(negedge clk);
                check("rst_frame_done", frame_done, 0);
            end
            @(posedge clk); #1;
            rst = 1'b1;
        end else begin
            check("conv_starts", starts, exp_bands);
            check("frame_done_count", fd_cnt, 1);
            check("writes_left", exp_q.size(), 0);
            mon_en = 0;
        end
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_frame_done", frame_done, 0);
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.conv_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_busy", busy, 0);
            check("reset_pix_ready", bus.pix_ready, 0);
            check("reset_wr_en", bus.lb_wr_en, 0);
            check("reset_conv_start", bus.conv_start, 0);
            check("reset_frame_done", frame_done, 0);
            check("reset_r1", bus.lb_data_r1, 0);
            check("reset_r2", bus.lb_data_r2, 0);
            check("reset_r3", bus.lb_data_r3, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_no_start_busy", busy, 0);
            check("idle_no_start_ready", bus.pix_ready, 0);
        end
        run_frame(1, 1'b1, 0,  0, 5,  -1);
        run_frame(2, 1'b1, 0,  0, 5,  -1);
        run_frame(3, 1'b0, 30, 1, 50, -1);
        run_frame(0, 1'b0, 50, 2, 0,  -1);
        run_frame(1, 1'b0, 20, 1, 20, 10 * COLS + 5);
        run_frame(2, 1'b0, 25, 1, 50, -1);
        run_frame(1, 1'b0, 10, 2, 0,  -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
